aes_core_arbiter: RTL and testbench
===================================

# aes_core_arbiter

- Shares one `aes_cipher_top` encryption core between two requesters.
- Arbitrates round-robin between the two request ports.
- Sequences the core's one-cycle `ld` pulse and captures `cypher_text` on `done`.
- Returns each result, with an error flag, on the owning requester's response port.
- Includes a watchdog that aborts and returns an error if `done` never arrives.

## Interface
Parameters:
- TIMEOUT, 32, maximum cycles spent waiting for core `done` before the arbiter aborts with an error (must be ≥ 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- req0_valid / req1_valid  in  1  requester N presents a job.
- req0_ready / req1_ready  out  1  arbiter accepts requester N's job this cycle.
- req0_key / req1_key  in  128  AES-128 key for the job.
- req0_text / req1_text  in  128  plaintext block for the job.
- rsp0_valid / rsp1_valid  out  1  result available for requester N.
- rsp0_ready / rsp1_ready  in  1  requester N consumes the result.
- rsp_data  out  128  ciphertext; zero on error.
- rsp_err  out  1  watchdog abort for the current response.
- core_ld  out  1  one-cycle load strobe to the core.
- core_key  out  128  key driven to the core.
- core_text  out  128  plaintext driven to the core.
- core_done  in  1  core result strobe.
- core_cypher  in  128  core ciphertext, valid when `core_done` is high.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE
  - Grant goes to the requester that was not served last (`last_grant` pointer).
  - If only one requester is valid, it is granted.
  - `reqN_ready` is high only for the granted requester, only in IDLE, only while its valid is high. It is a combinational function of state, pointer and the valids.
  - On valid&ready: latch key, text and owner id; go to LOAD.
- LOAD
  - `core_ld`=1 for exactly this cycle.
  - `core_key`/`core_text` drive the latched values; they stay stable through LOAD and WAIT.
  - Clear the watchdog; go to WAIT.
- WAIT
  - The watchdog increments each cycle.
  - If `core_done`=1: capture `core_cypher` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Else if watchdog == TIMEOUT-1: set `rsp_data`=0, `rsp_err`=1, go to RESP.
  - If `core_done` and timeout coincide, `done` wins.
- RESP
  - `rsp<owner>_valid`=1; `rsp_data`/`rsp_err` are held stable until `rsp<owner>_ready`=1.
  - On that handshake: `last_grant` ← owner; go to IDLE.
- `core_done` outside WAIT is ignored.
- Only one job is in flight; both `req*_ready` are low outside IDLE.
- The watchdog counter is $clog2(TIMEOUT) bits wide and saturates, never wraps.
- Reset values:
  - state=IDLE, `last_grant`=1 (so req0 wins the first tie).
  - All outputs 0: `req*_ready`, `rsp*_valid`, `rsp_data`, `rsp_err`, `core_ld`, `core_key`, `core_text`, `busy`.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The in-flight job is discarded, and a late `core_done` is ignored.

## Timing
- Edge E0: request handshake.
- Cycle after E0: LOAD, `core_ld`=1, `busy`=1.
- Next cycle: WAIT.
- `core_done` sampled at edge Ek → RESP (`rsp valid`) in the cycle after Ek.
- Back-to-back: a new request can be accepted in the cycle after the RESP handshake, giving a minimum two-cycle arbitration overhead per job beyond core latency.
- Timeout: with no `done`, WAIT lasts exactly TIMEOUT cycles, then RESP with `rsp_err`=1.
- `core_ld` is never high for two consecutive cycles and never high outside LOAD.

## Test plan
- Single job: req0, key=0, text=FFFF…FF.
  - Exactly one `core_ld` pulse, one cycle after the handshake.
  - `rsp0_valid` with `rsp_data`=3f5b8cc9ea855a0afa7347d23e8d664e, `rsp_err`=0.
  - `rsp1_valid` never asserts.
- Tie after reset: req0 (key 0, text FF…FF) and req1 (key 000102…0f, text 00112233445566778899aabbccddeeff) valid in the same cycle.
  - req0 is served first → 3f5b…664e.
  - req1 is served next → 69c4e0d86a7b0430d8cdb78070b4c55a.
  - A following simultaneous pair again grants req0 first.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles with req1 valid.
  - `rsp0_valid` and `rsp_data` stay stable.
  - `req1_ready`=0, no `core_ld`.
  - req1 is accepted the cycle after `rsp0_ready` rises.
- Timeout: TIMEOUT=32, core stub never asserts `done`.
  - `rsp0_valid` rises 32 cycles after WAIT entry with `rsp_err`=1, `rsp_data`=0.
  - `busy` drops after the handshake.
- Reset in WAIT: assert `rst` for 1 cycle mid-job, then pulse `core_done`.
  - All outputs are 0 the cycle after reset.
  - The late `done` produces no response.
  - A fresh req1 job then returns the correct ciphertext.
- Spurious `core_done` in IDLE and RESP: no state change, `rsp_data` is unchanged, no response is emitted.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// aes_core_arbiter
//
// Shares a single AES-128 encryption core between two requesters. Jobs are
// granted round-robin, sent to the core with a one-cycle load strobe, and
// the ciphertext is returned on the owning requester's response port. A
// watchdog aborts a job whose core never signals done; the response then
// carries an error flag and zero data.
//
// Parameters
//   TIMEOUT      max WAIT cycles before abort (must be >= 2)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/ready/key/text    job request channel, N = 0/1
//   rspN_valid/ready             response handshake, N = 0/1
//   rsp_data, rsp_err            shared response payload
//   core_ld/key/text             load interface to the AES core
//   core_done, core_cypher       result interface from the AES core
//   busy                         high whenever a job is in flight
// -----------------------------------------------------------------------------
module aes_core_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_key,
  input  logic [127:0] req0_text,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_key,
  input  logic [127:0] req1_text,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  input  logic         core_done,
  input  logic [127:0] core_cypher,
  output logic         busy
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic [127:0]      key_q;
  logic [127:0]      text_q;
  logic [127:0]      rsp_data_q;
  logic              rsp_err_q;
  logic [WD_W-1:0]   wdog_q;

  logic              grant;
  logic              accept;
  logic              rsp_hs;
  logic              timeout_hit;

  // Tie goes to the requester not served last; a lone requester always wins.
  assign grant       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept      = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign rsp_hs      = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  assign timeout_hit = (wdog_q == WD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_WAIT;
      // done and timeout lead to the same state; the datapath gives done priority
      ST_WAIT: if (core_done || timeout_hit) state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && req0_valid && !grant;
    req1_ready = (state_q == ST_IDLE) && req1_valid && grant;
    core_ld    = (state_q == ST_LOAD);
    busy       = (state_q != ST_IDLE);
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) && owner_q;
  end

  assign core_key  = key_q;
  assign core_text = text_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Job datapath, watchdog and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      key_q        <= '0;
      text_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant;
            key_q   <= grant ? req1_key  : req0_key;
            text_q  <= grant ? req1_text : req0_text;
          end
        end
        ST_LOAD: begin
          wdog_q <= '0;
        end
        ST_WAIT: begin
          // Saturating count: never wraps back into a valid waiting window.
          if (wdog_q != {WD_W{1'b1}}) begin
            wdog_q <= wdog_q + 1'b1;
          end
          if (core_done) begin
            rsp_data_q <= core_cypher;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            last_grant_q <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
module tb_aes_core_arbiter;

  localparam int TIMEOUT = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_key, req0_text, req1_key, req1_text;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         core_ld;
  logic [127:0] core_key, core_text;
  logic         core_done;
  logic [127:0] core_cypher;
  logic         busy;

  always #5 clk = ~clk;

  aes_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_key   (req0_key),
    .req0_text  (req0_text),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_key   (req1_key),
    .req1_text  (req1_text),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .core_ld    (core_ld),
    .core_key   (core_key),
    .core_text  (core_text),
    .core_done  (core_done),
    .core_cypher(core_cypher),
    .busy       (busy)
  );

  localparam logic [127:0] K_ZERO = 128'h0;
  localparam logic [127:0] T_ONES = {128{1'b1}};
  localparam logic [127:0] C_A    = 128'h3f5b8cc9ea855a0afa7347d23e8d664e;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_B    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model state
  bit           pend [2];
  logic [127:0] pkey [2];
  logic [127:0] ptext[2];
  bit           last_g;
  logic [127:0] last_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core stand-in: known AES-128 vectors, otherwise a fixed scrambling.
  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] t);
    if (k == K_ZERO && t == T_ONES) return C_A;
    if (k == K_SEQ && t == T_SEQ) return C_B;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_1234_c3c3_8765_0f0f_abcd_f0f0_9999;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_reqs();
    req0_valid = pend[0];
    req0_key   = pkey[0];
    req0_text  = ptext[0];
    req1_valid = pend[1];
    req1_key   = pkey[1];
    req1_text  = ptext[1];
  endtask

  // Entered just after a negedge with the DUT idle and at least one job pending.
  // d: WAIT cycle index in which the core reports done (>= TIMEOUT means never).
  // h: extra cycles the owner withholds rsp_ready.  spur: junk done in RESP.
  task automatic serve(input int d, input int h, input bit spur);
    int           w;
    int           wait_n;
    logic [127:0] ek, et, exp_d;
    logic         exp_e;
    w  = (pend[0] && pend[1]) ? int'(!last_g) : (pend[0] ? 0 : 1);
    ek = pkey[w];
    et = ptext[w];
    drive_reqs();
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_rdy0", req0_ready, (w == 0));
    chk("idle_rdy1", req1_ready, (w == 1));
    @(negedge clk);
    pend[w] = 1'b0;
    drive_reqs();
    #1;
    chk("load_ld", core_ld, 1);
    chk("load_busy", busy, 1);
    chk("load_key", core_key, ek);
    chk("load_text", core_text, et);
    chk("load_rdy", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    wait_n = (d < TIMEOUT) ? d : TIMEOUT - 1;
    for (int i = 0; i <= wait_n; i++) begin
      #1;
      chk("wait_ld", core_ld, 0);
      chk("wait_rsp", {rsp0_valid, rsp1_valid}, 0);
      chk("wait_rdy", {req0_ready, req1_ready}, 0);
      chk("wait_key", core_key, ek);
      chk("wait_text", core_text, et);
      if (i == d) begin
        core_done   = 1'b1;
        core_cypher = core_model(ek, et);
      end else begin
        core_done   = 1'b0;
        core_cypher = rnd128();
      end
      @(negedge clk);
    end
    core_done = 1'b0;
    exp_d = (d < TIMEOUT) ? core_model(ek, et) : 128'h0;
    exp_e = (d >= TIMEOUT);
    for (int j = 0; j <= h; j++) begin
      if (w == 0) begin
        rsp0_ready = (j == h);
        rsp1_ready = 1'($urandom_range(0, 1));
      end else begin
        rsp1_ready = (j == h);
        rsp0_ready = 1'($urandom_range(0, 1));
      end
      core_done   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      core_cypher = rnd128();
      #1;
      chk("resp_v0", rsp0_valid, (w == 0));
      chk("resp_v1", rsp1_valid, (w == 1));
      chk("resp_data", rsp_data, exp_d);
      chk("resp_err", rsp_err, exp_e);
      chk("resp_busy", busy, 1);
      chk("resp_ld", core_ld, 0);
      chk("resp_rdy", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    core_done  = 1'b0;
    last_g     = w[0];
    last_data  = exp_d;
    #1;
    chk("post_busy", busy, 0);
    chk("post_rsp", {rsp0_valid, rsp1_valid}, 0);
    $display("job: port=%0d d=%0d h=%0d data=%h err=%0d", w, d, h, exp_d, exp_e);
  endtask

  // Idle cycles with no requests; spurious done must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      core_done   = 1'($urandom_range(0, 1));
      core_cypher = rnd128();
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_rsp", {rsp0_valid, rsp1_valid}, 0);
      chk("idle_data", rsp_data, last_data);
      chk("idle_ld", core_ld, 0);
      @(negedge clk);
    end
    core_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    core_done = 1'b0;
    core_cypher = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      pkey[p] = '0;
      ptext[p] = '0;
    end
    drive_reqs();
    last_g = 1'b1;
    last_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ld", core_ld, 0);
    chk("rst_key", core_key, 0);
    chk("rst_text", core_text, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    idle_cycles(2);

    // Single req0 job with the known vector
    pend[0] = 1; pkey[0] = K_ZERO; ptext[0] = T_ONES;
    serve(4, 0, 0);
    idle_cycles(1);

    // Tie: req0 first, then req1, then a second tie goes to req0 again
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    last_g = 1'b1; last_data = '0;
    pend[0] = 1; pkey[0] = K_ZERO; ptext[0] = T_ONES;
    pend[1] = 1; pkey[1] = K_SEQ;  ptext[1] = T_SEQ;
    serve(2, 0, 0);
    serve(3, 0, 0);
    pend[0] = 1; pkey[0] = rnd128(); ptext[0] = rnd128();
    pend[1] = 1; pkey[1] = rnd128(); ptext[1] = rnd128();
    serve(1, 0, 0);
    // Backpressure on the leftover req1 job while a new req0 waits
    pend[0] = 1; pkey[0] = rnd128(); ptext[0] = rnd128();
    serve(0, 5, 1);
    serve(2, 0, 0);

    // Watchdog: done never arrives, done on the last allowed cycle, one late
    pend[0] = 1; pkey[0] = rnd128(); ptext[0] = rnd128();
    serve(1000, 1, 1);
    pend[1] = 1; pkey[1] = rnd128(); ptext[1] = rnd128();
    serve(TIMEOUT - 1, 0, 0);
    pend[0] = 1; pkey[0] = rnd128(); ptext[0] = rnd128();
    serve(TIMEOUT, 0, 0);
    idle_cycles(2);

    // Reset while waiting on the core, then a late done
    pend[0] = 1; pkey[0] = rnd128(); ptext[0] = rnd128();
    drive_reqs();
    @(negedge clk);
    pend[0] = 0;
    drive_reqs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1; last_data = '0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_ld", core_ld, 0);
    chk("mrst_key", core_key, 0);
    chk("mrst_text", core_text, 0);
    chk("mrst_data", rsp_data, 0);
    chk("mrst_err", rsp_err, 0);
    chk("mrst_rsp", {rsp0_valid, rsp1_valid}, 0);
    core_done = 1'b1;
    core_cypher = rnd128();
    @(negedge clk);
    core_done = 1'b0;
    idle_cycles(3);
    pend[1] = 1; pkey[1] = K_SEQ; ptext[1] = T_SEQ;
    serve(5, 0, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int d;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1; pkey[p] = rnd128(); ptext[p] = rnd128();
        end
      end
      if (!pend[0] && !pend[1]) begin
        idle_cycles($urandom_range(1, 3));
        pend[it % 2] = 1; pkey[it % 2] = rnd128(); ptext[it % 2] = rnd128();
      end
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
        default: d = $urandom_range(0, 8);
      endcase
      serve(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
